// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP add/sub unit between NREQ requesters,
// one operation in flight, with unit reset/strobe sequencing and a WAIT watchdog.
module fp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_z,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_sel,
  output logic                 add_rst,
  input  logic [31:0]          add_z,
  input  logic                 add_z_stb
);

  localparam int          WDW  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [WDW-1:0]   wd;

  logic             found;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   next_ptr;
  logic [IDW:0]     rr_sum;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_sub;

  // Search starts at rr_ptr and wraps modulo NREQ; NREQ need not be a power of two.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    rr_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(NREQ))
        rr_sum = rr_sum - (IDW+1)'(NREQ);
      if (!found && req_valid[rr_sum[IDW-1:0]]) begin
        found = 1'b1;
        grant = rr_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (found && state == IDLE && !rst)
      req_ready[grant] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      wd          <= '0;
      add_rst     <= 1'b1;
      add_a       <= '0;
      add_b       <= '0;
      add_sel     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_id      <= '0;
      rsp_z       <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          add_rst <= 1'b1;
          wd      <= '0;
          if (found) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_sel <= sel_sub;
            cur_id  <= grant;
            rr_ptr  <= next_ptr;
            state   <= ISSUE;
          end
        end
        // Unit is still held in reset here so it sees stable operands on release.
        ISSUE: begin
          add_rst <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          wd <= wd + WDW'(1);
          if (add_z_stb) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_z     <= add_z;
            state     <= RESP;
          end else if (wd == WDW'(TIMEOUT)) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_z       <= QNAN;
            state       <= RESP;
          end
        end
        RESP: begin
          add_rst <= 1'b1;
          wd      <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural stub of the FP add unit.
module tb_fp_add_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 1023;
  localparam logic [31:0] GARB = 32'h7F7F_7F7F;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_z;
  logic                rsp_timeout;
  logic                busy;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic                add_sel;
  logic                add_rst;
  logic [31:0]         add_z;
  logic                add_z_stb;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_timeout(rsp_timeout),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_rst(add_rst),
    .add_z(add_z), .add_z_stb(add_z_stb)
  );

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    int          lat;
    bit          dead;
    logic [31:0] z;
    logic        to;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          stub_cnt = 0;
  int          stub_lat = 3;
  bit          stub_dead = 1'b0;
  int          force_cyc = 0;
  logic [31:0] force_z = 32'h3F80_0000;
  logic [NREQ-1:0] ready_snap;

  int          gq_id[$];
  int          gq_cyc[$];
  int          rq_id[$];
  int          rq_cyc[$];
  logic [31:0] rq_z[$];
  logic        rq_to[$];

  // Stub unit's arithmetic: a lookup of exactly-representable results.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic sel);
    case ({sel, a, b})
      {1'b0, 32'h3F800000, 32'h3F800000}: fp_ref = 32'h40000000;
      {1'b1, 32'h40400000, 32'h3F800000}: fp_ref = 32'h40000000;
      {1'b1, 32'h40A00000, 32'h40A00000}: fp_ref = 32'h00000000;
      {1'b0, 32'h40000000, 32'h40400000}: fp_ref = 32'h40A00000;
      {1'b1, 32'h41200000, 32'h40A00000}: fp_ref = 32'h40A00000;
      {1'b0, 32'h3F000000, 32'h3F000000}: fp_ref = 32'h3F800000;
      {1'b0, 32'hC0000000, 32'h40800000}: fp_ref = 32'h40000000;
      {1'b0, 32'h40000000, 32'h3F800000}: fp_ref = 32'h40400000;
      {1'b0, 32'h40400000, 32'h3F800000}: fp_ref = 32'h40800000;
      {1'b0, 32'h40800000, 32'h3F800000}: fp_ref = 32'h40A00000;
      default:                            fp_ref = 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_unit();
    logic fire;
    fire = !add_rst && !stub_dead && (stub_cnt == stub_lat);
    add_z_stb = fire || (force_cyc > 0);
    add_z = fire ? fp_ref(add_a, add_b, add_sel) : force_z;
  endtask

  task automatic step();
    @(negedge clk);
    ready_snap = req_ready;
    chk("ready_onehot", 32'($onehot0(req_ready) && !(busy && (req_ready != '0))), 32'd1);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && req_valid[i]) begin
        gq_id.push_back(i);
        gq_cyc.push_back(cyc + 1);
      end
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_valid) begin
      rq_id.push_back(int'(rsp_id));
      rq_z.push_back(rsp_z);
      rq_to.push_back(rsp_timeout);
      rq_cyc.push_back(cyc);
    end
    if (force_cyc > 0) force_cyc--;
    if (add_rst) stub_cnt = 0;
    else stub_cnt++;
    drive_unit();
  endtask

  task automatic clear_q();
    gq_id.delete(); gq_cyc.delete();
    rq_id.delete(); rq_cyc.delete(); rq_z.delete(); rq_to.delete();
  endtask

  task automatic wait_acc(input int n, input int bound, input string tag);
    int t;
    t = 0;
    while (gq_id.size() < n && t < bound) begin step(); t++; end
    chk({tag, "_accept_wait"}, 32'(gq_id.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input int bound, input string tag);
    int t;
    t = 0;
    while (rq_id.size() < n && t < bound) begin step(); t++; end
    chk({tag, "_rsp_wait"}, 32'(rq_id.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    force_cyc = 0;
    step();
    step();
    rst = 1'b0;
    clear_q();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear_q();
    stub_lat  = v.lat;
    stub_dead = v.dead;
    req_a = {NREQ{GARB}};
    req_b = {NREQ{GARB}};
    req_sub = '0;
    req_a[32*v.req +: 32] = v.a;
    req_b[32*v.req +: 32] = v.b;
    req_sub[v.req] = v.sub;
    req_valid = '0;
    req_valid[v.req] = 1'b1;
    wait_acc(1, 20, tag);
    req_valid = '0;
    req_a = {NREQ{GARB}};
    req_b = {NREQ{GARB}};
    req_sub = '1;
    wait_rsp(1, v.exp_lat + 20, tag);
    if (gq_id.size() >= 1 && rq_id.size() >= 1) begin
      chk({tag, "_grant"}, gq_id[0], v.req);
      chk({tag, "_id"}, rq_id[0], v.req);
      chk({tag, "_z"}, rq_z[0], v.z);
      chk({tag, "_to"}, 32'(rq_to[0]), 32'(v.to));
      chk({tag, "_lat"}, rq_cyc[0] - gq_cyc[0], v.exp_lat);
    end
    repeat (3) step();
    chk({tag, "_single"}, rq_id.size(), 1);
    stub_dead = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [31:0] rr_a[NREQ];
    logic [31:0] rr_z[NREQ];

    vt[0] = '{0, 32'h3F800000, 32'h3F800000, 1'b0, 3, 1'b0, 32'h40000000, 1'b0, 4};
    vt[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 2, 1'b0, 32'h40000000, 1'b0, 3};
    vt[2] = '{2, 32'h40A00000, 32'h40A00000, 1'b1, 5, 1'b0, 32'h00000000, 1'b0, 6};
    vt[3] = '{1, 32'h40000000, 32'h40400000, 1'b0, 1, 1'b0, 32'h40A00000, 1'b0, 2};
    vt[4] = '{3, 32'h41200000, 32'h40A00000, 1'b1, 4, 1'b0, 32'h40A00000, 1'b0, 5};
    vt[5] = '{0, 32'h3F000000, 32'h3F000000, 1'b0, 3, 1'b1, 32'h7FC00000, 1'b1, TIMEOUT + 2};
    vt[6] = '{1, 32'h3F000000, 32'h3F000000, 1'b0, 2, 1'b0, 32'h3F800000, 1'b0, 3};
    vt[7] = '{3, 32'hC0000000, 32'h40800000, 1'b0, TIMEOUT + 1, 1'b0, 32'h40000000, 1'b0, TIMEOUT + 2};

    rr_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    rr_z = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    add_z = '0;
    add_z_stb = 1'b0;

    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_add_sel", 32'(add_sel), 32'd0);
    chk("rst_add_rst", 32'(add_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    clear_q();

    for (int i = 0; i < 8; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // Spurious strobes while idle must not produce a response.
    clear_q();
    force_z = 32'h3F800000;
    force_cyc = 3;
    drive_unit();
    repeat (5) step();
    chk("spur_idle_norsp", rq_id.size(), 0);
    chk("spur_idle_busy", 32'(busy), 32'd0);

    // Spurious strobe during ISSUE is ignored; the real result follows.
    clear_q();
    stub_lat = 4;
    req_a = {NREQ{GARB}};
    req_b = {NREQ{GARB}};
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h3F800000;
    req_sub = '0;
    req_valid = 4'b0001;
    wait_acc(1, 20, "spur_issue");
    req_valid = '0;
    force_z = 32'h12345678;
    force_cyc = 1;
    drive_unit();
    wait_rsp(1, 40, "spur_issue");
    repeat (3) step();
    chk("spur_issue_count", rq_id.size(), 1);
    if (rq_id.size() >= 1 && gq_cyc.size() >= 1) begin
      chk("spur_issue_z", rq_z[0], 32'h40000000);
      chk("spur_issue_lat", rq_cyc[0] - gq_cyc[0], 5);
    end

    // Reset in the middle of WAIT aborts silently and clears the pointer.
    clear_q();
    stub_lat = 40;
    req_a = {NREQ{GARB}};
    req_b = {NREQ{GARB}};
    req_a[64 +: 32] = 32'h40400000;
    req_b[64 +: 32] = 32'h3F800000;
    req_sub = 4'b0100;
    req_valid = 4'b0100;
    wait_acc(1, 20, "midrst");
    req_valid = '0;
    repeat (6) step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_add_rst", 32'(add_rst), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    repeat (50) step();
    chk("midrst_norsp", rq_id.size(), 0);
    clear_q();
    stub_lat = 2;
    req_a[32 +: 32] = 32'h40000000;
    req_b[32 +: 32] = 32'h40400000;
    req_a[96 +: 32] = 32'h40800000;
    req_b[96 +: 32] = 32'h3F800000;
    req_sub = '0;
    req_valid = 4'b1010;
    wait_acc(1, 20, "midrst_after");
    chk("midrst_ready", 32'(ready_snap), 32'b0010);
    req_valid = '0;
    wait_rsp(1, 40, "midrst_after");
    if (gq_id.size() >= 1 && rq_id.size() >= 1) begin
      chk("midrst_grant", gq_id[0], 1);
      chk("midrst_id", rq_id[0], 1);
      chk("midrst_z", rq_z[0], 32'h40A00000);
      chk("midrst_to", 32'(rq_to[0]), 32'd0);
    end
    repeat (3) step();

    // Round-robin with every requester asserting continuously.
    do_reset();
    stub_lat = 3;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = rr_a[i];
      req_b[32*i +: 32] = 32'h3F800000;
    end
    req_sub = '0;
    req_valid = '1;
    for (int t = 0; t < 200 && gq_id.size() < 5; t++) step();
    req_valid = '0;
    chk("rr_accepts", gq_id.size(), 5);
    wait_rsp(5, 40, "rr");
    repeat (3) step();
    chk("rr_rsp_count", rq_id.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gq_id.size()) chk($sformatf("rr_grant%0d", i), gq_id[i], i % NREQ);
      if (i < rq_id.size()) begin
        chk($sformatf("rr_id%0d", i), rq_id[i], i % NREQ);
        chk($sformatf("rr_z%0d", i), rq_z[i], rr_z[i % NREQ]);
      end
    end
    if (gq_cyc.size() >= 2)
      chk("rr_spacing", gq_cyc[1] - gq_cyc[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
